// File: rtl/fp_conv_sched.sv
// rtl/fp_conv_sched.sv - shared 12-bit two's-complement to sign/E3/F4 float converter, two requesters
// Optional FP_SAT_FLAG_EN adds out_sat (round/exponent saturation or 12'h800 magnitude clamp).
module fp_conv_sched #(
  parameter int FAIR_RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [11:0] in0_data,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [11:0] in1_data,
  output logic        in1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [2:0]  out_exp,
  output logic [3:0]  out_sig,
  output logic        out_id
`ifdef FP_SAT_FLAG_EN
  ,
  output logic        out_sat
`endif
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] m_q, m_d;
  logic [2:0]  sh_q, sh_d;
  logic        sign_q, sign_d;
  logic        id_q, id_d;
  logic        rr_q, rr_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sign_q, out_sign_d;
  logic [2:0]  out_exp_q, out_exp_d;
  logic [3:0]  out_sig_q, out_sig_d;
  logic        out_id_q, out_id_d;
`ifdef FP_SAT_FLAG_EN
  logic        clamp_q, clamp_d;
  logic        out_sat_q, out_sat_d;
`endif

  logic        idle_ok;
  logic        gnt_id;
  logic        accept;
  logic [11:0] sel_data;
  logic [11:0] mag12;
  logic [10:0] m_in;
  logic        fifth;
  logic [4:0]  f_sum;
  logic [3:0]  e_sum;
  logic        rnd_ovf;

  // Requester 1 wins alone, or on a tie when the round-robin pointer favours it.
  assign idle_ok  = (state_q == IDLE) && !rst;
  assign gnt_id   = (in0_valid && in1_valid) ? ((FAIR_RR != 0) ? rr_q : 1'b0)
                                             : (in1_valid && !in0_valid);
  assign accept   = idle_ok && (in0_valid || in1_valid);
  assign in0_ready = accept && !gnt_id;
  assign in1_ready = accept && gnt_id;
  assign sel_data = gnt_id ? in1_data : in0_data;
  assign mag12    = sel_data[11] ? (~sel_data + 12'd1) : sel_data;
  assign m_in     = mag12[11] ? 11'h7FF : mag12[10:0];

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    sh_d        = sh_q;
    sign_d      = sign_q;
    id_d        = id_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    out_id_d    = out_id_q;
`ifdef FP_SAT_FLAG_EN
    clamp_d     = clamp_q;
    out_sat_d   = out_sat_q;
`endif
    // At E=0 the value is denormal-like, so no bit below F exists to round on.
    fifth   = m_q[6] && (sh_q != 3'd7);
    f_sum   = {1'b0, m_q[10:7]} + {4'b0000, fifth};
    e_sum   = {1'b0, 3'd7 - sh_q};
    rnd_ovf = 1'b0;
    if (f_sum[4]) begin
      f_sum = 5'd8;
      e_sum = e_sum + 4'd1;
    end
    if (e_sum[3]) begin
      e_sum   = 4'd7;
      f_sum   = 5'd15;
      rnd_ovf = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d  = sel_data[11];
          m_d     = m_in;
          sh_d    = 3'd0;
          id_d    = gnt_id;
          rr_d    = !gnt_id;
`ifdef FP_SAT_FLAG_EN
          clamp_d = mag12[11];
`endif
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q[10] || (sh_q == 3'd7)) begin
          state_d = ROUND;
        end else begin
          m_d  = {m_q[9:0], 1'b0};
          sh_d = sh_q + 3'd1;
        end
      end
      ROUND: begin
        out_valid_d = 1'b1;
        out_sign_d  = sign_q;
        out_exp_d   = e_sum[2:0];
        out_sig_d   = f_sum[3:0];
        out_id_d    = id_q;
`ifdef FP_SAT_FLAG_EN
        out_sat_d   = rnd_ovf || clamp_q;
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      sh_q        <= '0;
      sign_q      <= 1'b0;
      id_q        <= 1'b0;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_id_q    <= 1'b0;
`ifdef FP_SAT_FLAG_EN
      clamp_q     <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      sh_q        <= sh_d;
      sign_q      <= sign_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
      out_id_q    <= out_id_d;
`ifdef FP_SAT_FLAG_EN
      clamp_q     <= clamp_d;
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_id    = out_id_q;
`ifdef FP_SAT_FLAG_EN
  assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_fp_conv_sched.sv
// tb/tb_fp_conv_sched.sv - self-checking bench for fp_conv_sched against an arithmetic reference
// Honours FP_SAT_FLAG_EN to also check out_sat.
module tb_fp_conv_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in0_valid, in1_valid, out_ready;
  logic [11:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, out_sign, out_id;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
`ifdef FP_SAT_FLAG_EN
  logic        out_sat, b_out_sat;
`endif

  logic        b_in0_valid, b_in1_valid, b_out_ready;
  logic [11:0] b_in0_data, b_in1_data;
  logic        b_in0_ready, b_in1_ready, b_out_valid, b_out_sign, b_out_id;
  logic [2:0]  b_out_exp;
  logic [3:0]  b_out_sig;

  int checks = 0;
  int failures = 0;
  bit ptr;

  fp_conv_sched #(.FAIR_RR(1)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_sig(out_sig), .out_id(out_id)
`ifdef FP_SAT_FLAG_EN
    , .out_sat(out_sat)
`endif
  );

  fp_conv_sched #(.FAIR_RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .in0_valid(b_in0_valid), .in0_data(b_in0_data), .in0_ready(b_in0_ready),
    .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sign(b_out_sign),
    .out_exp(b_out_exp), .out_sig(b_out_sig), .out_id(b_out_id)
`ifdef FP_SAT_FLAG_EN
    , .out_sat(b_out_sat)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // value = F * 2^E: E is how far the magnitude sits above a 4-bit field, F rounds half-up.
  function automatic void ref_conv(input logic [11:0] d, output int s, output int e,
                                   output int f, output int sat, output int lat);
    int v, m, epre;
    v = d[11] ? int'(d) - 4096 : int'(d);
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    s = (v < 0) ? 1 : 0;
    epre = 0;
    for (int k = 4; k <= 10; k++) if (m >= (1 << k)) epre = k - 3;
    e = epre;
    f = (e == 0) ? m : ((m + (1 << (e - 1))) >> e);
    sat = (d == 12'h800) ? 1 : 0;
    if (f == 16) begin
      f = 8;
      e = e + 1;
    end
    if (e == 8) begin
      e = 7;
      f = 15;
      sat = 1;
    end
    lat = 9 - epre;
  endfunction

  task automatic serve(input bit keep, input int hold);
    bit w;
    logic [11:0] d;
    int s, e, f, sat, lat, n;
    #1;
    w = (in0_valid && in1_valid) ? ptr : (in1_valid && !in0_valid);
    d = w ? in1_data : in0_data;
    ref_conv(d, s, e, f, sat, lat);
    chk("in0_ready", 32'(in0_ready), 32'(!w));
    chk("in1_ready", 32'(in1_ready), 32'(w));
    @(posedge clk); #1;
    ptr = !w;
    if (w) begin
      if (keep) in1_data = 12'($urandom); else in1_valid = 1'b0;
    end else begin
      if (keep) in0_data = 12'($urandom); else in0_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("out_sign", 32'(out_sign), 32'(s));
    chk("out_exp", 32'(out_exp), 32'(e));
    chk("out_sig", 32'(out_sig), 32'(f));
    chk("out_id", 32'(out_id), 32'(w));
`ifdef FP_SAT_FLAG_EN
    chk("out_sat", 32'(out_sat), 32'(sat));
`endif
    chk("ready_busy", 32'(in0_ready | in1_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", {24'd0, out_sign, out_exp, out_sig}, 32'({s[0], e[2:0], f[3:0]}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  logic [11:0] dir_data [6] = '{12'h000, 12'd422, 12'hE5A, 12'd124, 12'h7FF, 12'h800};
  bit          dir_req  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n, r;
    rst = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b0; in0_data = 12'd7; in1_data = '0; out_ready = 1'b0;
    b_in0_valid = 1'b0; b_in1_valid = 1'b0; b_in0_data = '0; b_in1_data = '0; b_out_ready = 1'b1;
    ptr = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(in0_ready), 32'd0);
    chk("rst_out", {26'd0, out_valid, out_sign, out_exp, out_sig, out_id} , 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in0_valid = 1'b0;

    // Fixed priority: requester 0 always wins ties.
    b_in0_valid = 1'b1; b_in1_valid = 1'b1;
    b_in0_data = 12'($urandom); b_in1_data = 12'($urandom);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_in0_ready", 32'(b_in0_ready), 32'd1);
      chk("fp_in1_ready", 32'(b_in1_ready), 32'd0);
      @(posedge clk); #1;
      b_in0_data = 12'($urandom);
      n = 0;
      while (!b_out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("fp_seen", 32'(b_out_valid), 32'd1);
      chk("fp_id", 32'(b_out_id), 32'd0);
      @(posedge clk); #1;
    end
    b_in0_valid = 1'b0; b_in1_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (dir_req[i]) begin in1_valid = 1'b1; in1_data = dir_data[i]; end
      else begin in0_valid = 1'b1; in0_data = dir_data[i]; end
      serve(1'b0, (i == 1) ? 2 : 0);
    end

    // Abort mid-normalisation; outputs still hold the saturated 12'h800 result.
    in0_valid = 1'b1; in0_data = 12'd5;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    in0_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_out", {26'd0, out_valid, out_sign, out_exp, out_sig, out_id}, 32'd0);
    chk("abort_ready", 32'(in0_ready), 32'd0);
    rst = 1'b0;
    ptr = 1'b0;
    serve(1'b0, 0);

    // Round-robin with both requesters continuously valid.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 12'($urandom); in1_data = 12'($urandom);
    for (int i = 0; i < 6; i++) serve(1'b1, (i == 0) ? 3 : 0);
    in0_valid = 1'b0; in1_valid = 1'b0;

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 2));
      in0_data = 12'($urandom); in1_data = 12'($urandom);
      in0_valid = (r != 1); in1_valid = (r != 0);
      serve(1'b0, int'($urandom_range(0, 2)));
      in0_valid = 1'b0; in1_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
